matvec_row_accum_ctrl: RTL and testbench

//  Sequencer for the COLS-wide signed vector-add datapath in the matrix unit.

---
 rtl/matvec_row_accum_ctrl_if.sv | 31 +++
 rtl/matvec_row_accum_ctrl.sv | 137 +++++++++++++
 tb/tb_matvec_row_accum_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/matvec_row_accum_ctrl_if.sv
// Row-stream / result-stream bundle for matvec_row_accum_ctrl.
// The master side drives rows, flush and out_ready; the slave side is the sequencer.
interface matvec_row_accum_ctrl_if #(
  parameter int COLS = 5,
  parameter int DW   = 32
);
  // Both streams use strict valid/ready: a transfer happens on a rising clock
  // edge where valid and ready are both 1; the producer holds data and valid
  // stable until that edge; ready may change at any time without conditions.
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [DW-1:0]            in_coef;
  logic [COLS-1:0][DW-1:0]  in_row;
  logic                     out_valid;
  logic                     out_ready;
  logic [COLS-1:0][DW-1:0]  out_vec;
  logic                     busy;
  logic                     sat_flag;
  logic [1:0]               state_dbg;

  modport master (
    output flush, in_valid, in_coef, in_row, out_ready,
    input  in_ready, out_valid, out_vec, busy, sat_flag, state_dbg
  );

  modport slave (
    input  flush, in_valid, in_coef, in_row, out_ready,
    output in_ready, out_valid, out_vec, busy, sat_flag, state_dbg
  );
endinterface

// File: rtl/matvec_row_accum_ctrl.sv
// Accumulates coef*row over ROWS accepted row beats into a COLS-wide result.
// Define MATVEC_SAT_EN for saturating arithmetic with a sticky sat_flag; default wraps.
module matvec_row_accum_ctrl #(
  parameter int ROWS = 3,
  parameter int COLS = 5,
  parameter int DW   = 32
) (
  input logic                    clk,
  input logic                    rst,
  matvec_row_accum_ctrl_if.slave m
);
  localparam int CW = (ROWS < 2) ? 1 : $clog2(ROWS + 1);
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           row_cnt_q, row_cnt_d;
  logic [COLS-1:0][DW-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic                    rdy_en_q;
  logic                    in_ready_int;
  logic                    beat;
  logic [COLS-1:0][DW-1:0] prod_r;
  logic [COLS-1:0][DW-1:0] sum_r;
  logic [COLS-1:0]         prod_sat;
  logic [COLS-1:0]         sum_sat;
`ifdef MATVEC_SAT_EN
  logic signed [2*DW-1:0]  prod_full [COLS];
  logic        [DW:0]      sum_wide  [COLS];
`endif

  // in_ready is held low through reset and the first edge after it.
  assign in_ready_int = rdy_en_q && (state_q != HOLD);
  assign beat         = m.in_valid && in_ready_int;

  assign m.in_ready  = in_ready_int;
  assign m.out_valid = (state_q == HOLD);
  assign m.busy      = (state_q != IDLE);
  assign m.out_vec   = acc_q;
  assign m.sat_flag  = sat_q;
  assign m.state_dbg = state_q;

  // Per-column product and running sum, reduced to DW bits.
  always_comb begin
    prod_r   = '0;
    sum_r    = '0;
    prod_sat = '0;
    sum_sat  = '0;
`ifdef MATVEC_SAT_EN
    for (int j = 0; j < COLS; j++) begin
      prod_full[j] = $signed(m.in_coef) * $signed(m.in_row[j]);
      if ((prod_full[j][2*DW-1:DW-1] == '0) || (prod_full[j][2*DW-1:DW-1] == '1)) begin
        prod_r[j] = prod_full[j][DW-1:0];
      end else begin
        prod_sat[j] = 1'b1;
        prod_r[j]   = prod_full[j][2*DW-1] ? SMIN : SMAX;
      end
      sum_wide[j] = {acc_q[j][DW-1], acc_q[j]} + {prod_r[j][DW-1], prod_r[j]};
      if (sum_wide[j][DW] != sum_wide[j][DW-1]) begin
        sum_sat[j] = 1'b1;
        sum_r[j]   = sum_wide[j][DW] ? SMIN : SMAX;
      end else begin
        sum_sat[j] = prod_sat[j];
        sum_r[j]   = sum_wide[j][DW-1:0];
      end
    end
`else
    for (int j = 0; j < COLS; j++) begin
      prod_r[j] = m.in_coef * m.in_row[j];
      sum_r[j]  = acc_q[j] + prod_r[j];
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    if (m.flush) begin
      state_d   = IDLE;
      row_cnt_d = '0;
      acc_d     = '0;
      sat_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (beat) begin
            acc_d = prod_r;
            sat_d = |prod_sat;
            if (ROWS == 1) begin
              state_d   = HOLD;
              row_cnt_d = '0;
            end else begin
              state_d   = ACCUM;
              row_cnt_d = CW'(1);
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_d = sum_r;
            sat_d = sat_q | (|sum_sat);
            if (row_cnt_q == CW'(ROWS - 1)) begin
              state_d   = HOLD;
              row_cnt_d = '0;
            end else begin
              row_cnt_d = row_cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (m.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      rdy_en_q  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_matvec_row_accum_ctrl.sv
// Directed bench for matvec_row_accum_ctrl with a queue-based result scoreboard.
// Expected saturation results are selected by MATVEC_SAT_EN.
module tb_matvec_row_accum_ctrl;
  localparam int ROWS = 3;
  localparam int COLS = 5;
  localparam int DW   = 32;
  localparam int VW   = COLS * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [VW-1:0] exp_q[$];
  logic          exp_sat_q[$];

  matvec_row_accum_ctrl_if #(.COLS(COLS), .DW(DW)) mif ();

  matvec_row_accum_ctrl #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .m   (mif.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec5(input int a, input int b, input int c, input int d, input int e);
    logic [COLS-1:0][DW-1:0] v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = e;
    return v;
  endfunction

  // driver tasks
  task automatic send_beat(input logic [DW-1:0] c, input logic [VW-1:0] r, input int gap);
    int n;
    n = 0;
    mif.in_valid = 1'b1;
    mif.in_coef  = c;
    mif.in_row   = r;
    while (!mif.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL beat_accept: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    @(negedge clk);
    mif.in_valid = 1'b0;
    mif.in_coef  = DW'($urandom);
    mif.in_row   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    repeat (gap) @(negedge clk);
  endtask

  task automatic expect_result(input logic [VW-1:0] v, input logic s);
    exp_q.push_back(v);
    exp_sat_q.push_back(s);
  endtask

  task automatic seq_basic(input int gap);
    send_beat(32'd2, vec5(1, 2, 3, 4, 5), gap);
    send_beat(32'd3, vec5(1, 1, 1, 1, 1), gap);
    expect_result(vec5(5, 7, 9, 11, 9), 1'b0);
    send_beat(32'd4, vec5(0, 0, 0, 0, -1), 0);
  endtask

  task automatic release_result(input string name);
    mif.out_ready = 1'b1;
    @(negedge clk);
    mif.out_ready = 1'b0;
    check({name, "_out_valid_after"}, VW'(mif.out_valid), VW'(0));
    check({name, "_in_ready_after"}, VW'(mif.in_ready), VW'(1));
  endtask

  // scoreboard monitor: pops whenever a result handshake is about to happen
  initial begin
    logic [VW-1:0] e;
    logic          es;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && mif.out_valid && mif.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got result %h, required no result", mif.out_vec);
        end else begin
          e  = exp_q.pop_front();
          es = exp_sat_q.pop_front();
          if (mif.out_vec !== e) begin
            n_fail++;
            $display("FAIL sb_out_vec: got %h expected %h", mif.out_vec, e);
          end
          check("sb_sat_flag", VW'(mif.sat_flag), VW'(es));
        end
      end
    end
  end

  initial begin
    mif.flush     = 1'b0;
    mif.in_valid  = 1'b0;
    mif.in_coef   = '0;
    mif.in_row    = '0;
    mif.out_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", VW'(mif.out_valid), VW'(0));
    check("rst_busy", VW'(mif.busy), VW'(0));
    check("rst_out_vec", mif.out_vec, '0);
    check("rst_sat_flag", VW'(mif.sat_flag), VW'(0));
    check("rst_state", VW'(mif.state_dbg), VW'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", VW'(mif.in_ready), VW'(1));

    // 1: basic, one-cycle latency
    seq_basic(0);
    check("t1_out_valid", VW'(mif.out_valid), VW'(1));
    check("t1_in_ready_hold", VW'(mif.in_ready), VW'(0));
    check("t1_busy", VW'(mif.busy), VW'(1));
    check("t1_sat_flag", VW'(mif.sat_flag), VW'(0));
    release_result("t1");

    // 2: gaps between beats and held-off consumer
    seq_basic(2);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", VW'(mif.out_valid), VW'(1));
      check("t2_hold_vec", mif.out_vec, vec5(5, 7, 9, 11, 9));
      check("t2_hold_in_ready", VW'(mif.in_ready), VW'(0));
      @(negedge clk);
    end
    release_result("t2");

    // 3: flush beats a same-cycle row beat
    send_beat(32'd2, vec5(1, 2, 3, 4, 5), 0);
    mif.flush    = 1'b1;
    mif.in_valid = 1'b1;
    mif.in_coef  = 32'd3;
    mif.in_row   = vec5(1, 1, 1, 1, 1);
    @(negedge clk);
    mif.flush    = 1'b0;
    mif.in_valid = 1'b0;
    check("t3_busy", VW'(mif.busy), VW'(0));
    check("t3_acc", mif.out_vec, '0);
    check("t3_state", VW'(mif.state_dbg), VW'(0));
    seq_basic(0);
    check("t3_out_valid", VW'(mif.out_valid), VW'(1));
    release_result("t3");

    // 4: asynchronous reset mid-accumulation
    send_beat(32'd2, vec5(1, 2, 3, 4, 5), 0);
    check("t4_pre_vec", mif.out_vec, vec5(2, 4, 6, 8, 10));
    #2 rst = 1'b1;
    #1;
    check("t4_rst_vec", mif.out_vec, '0);
    check("t4_rst_busy", VW'(mif.busy), VW'(0));
    check("t4_rst_valid", VW'(mif.out_valid), VW'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t4_in_ready", VW'(mif.in_ready), VW'(1));
    seq_basic(0);
    release_result("t4");

    // 5: overflow
    send_beat(32'h7FFF_FFFF, vec5(2, 2, 2, 2, 2), 0);
    send_beat(32'h7FFF_FFFF, vec5(0, 0, 0, 0, 0), 0);
`ifdef MATVEC_SAT_EN
    expect_result({COLS{32'h7FFF_FFFF}}, 1'b1);
    send_beat(32'h7FFF_FFFF, vec5(0, 0, 0, 0, 0), 0);
    check("t5_sat_flag", VW'(mif.sat_flag), VW'(1));
`else
    expect_result({COLS{32'hFFFF_FFFE}}, 1'b0);
    send_beat(32'h7FFF_FFFF, vec5(0, 0, 0, 0, 0), 0);
    check("t5_sat_flag", VW'(mif.sat_flag), VW'(0));
`endif
    release_result("t5");

    // 6: back-to-back sequences; second must reload, not add
    mif.out_ready = 1'b1;
    seq_basic(0);
    send_beat(32'd1, vec5(10, 20, 30, 40, 50), 0);
    send_beat(32'd1, vec5(1, 2, 3, 4, 5), 0);
    expect_result(vec5(10, 21, 32, 43, 54), 1'b0);
    send_beat(32'd1, vec5(-1, -1, -1, -1, -1), 0);
    @(negedge clk);
    mif.out_ready = 1'b0;
    check("t6_idle", VW'(mif.busy), VW'(0));

    repeat (3) @(negedge clk);
    check("sb_drained", VW'(exp_q.size()), VW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
